fetch_stage: RTL

//  LEGv8 instruction-fetch stage plus IF/ID register. Directly upstream of the main decoder.

---
 rtl/legv8_pkg.sv | 15 +
 rtl/fetch_stage_pc_register.sv | 21 ++
 rtl/fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and the fetch-stage state encoding.
package legv8_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 11;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// N-bit program-counter register with load enable and a configurable reset value.
module pc_register #(
    parameter int          N         = 64,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch with IF/ID register: stall, branch redirect and, with
// FETCH_HALT_EN defined, a halt on the all-zero instruction word.
module fetch_stage
    import legv8_pkg::*;
#(
    parameter int          N        = 64,
    parameter int          IMEM_AW  = 6,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [N-1:0]       branch_target_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [N-1:0]       pc_o,
    output logic               valid_o,
    output logic               halted_o
);

    fetch_state_t state_q, state_d;

    logic [N-1:0]       pc_q, pc_d;
    logic               pc_en;
    logic [N-1:0]       req_pc_q, req_pc_d;
    logic               req_valid_q, req_valid_d;
    logic [INSTR_W-1:0] instr_d;
    logic [N-1:0]       pc_out_d;
    logic               valid_d;
    logic [N-1:0]       target_aligned;
    logic               halt_hit;

    pc_register #(
        .N         (N),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pc_en),
        .d       (pc_d),
        .q       (pc_q)
    );

    // Low two bits of a byte target are dropped: instructions are word aligned.
    assign target_aligned = branch_target_i & ~{{(N-2){1'b0}}, 2'b11};

    // A stall re-reads the outstanding request so the returned word stays valid.
    assign imem_addr_o = stall_i ? req_pc_q[IMEM_AW+1:2] : pc_q[IMEM_AW+1:2];

`ifdef FETCH_HALT_EN
    assign halt_hit = req_valid_q && (imem_rdata_i == HALT_WORD);
    assign halted_o = (state_q == FS_HALT);
`else
    assign halt_hit = 1'b0;
    assign halted_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        instr_d     = instr_o;
        pc_out_d    = pc_o;
        valid_d     = valid_o;

        case (state_q)
            FS_BOOT: begin
                pc_en       = 1'b1;
                pc_d        = pc_q + N'(4);
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                state_d     = FS_RUN;
            end
            FS_RUN: begin
                if (branch_taken_i) begin
                    pc_en       = 1'b1;
                    pc_d        = target_aligned;
                    req_valid_d = 1'b0;
                    valid_d     = 1'b0;
                end else if (!stall_i) begin
                    instr_d  = imem_rdata_i;
                    pc_out_d = req_pc_q;
                    if (halt_hit) begin
                        // Halt word is captured but never presented as valid; fetch freezes.
                        valid_d = 1'b0;
                        state_d = FS_HALT;
                    end else begin
                        valid_d     = req_valid_q;
                        pc_en       = 1'b1;
                        pc_d        = pc_q + N'(4);
                        req_pc_d    = pc_q;
                        req_valid_d = 1'b1;
                    end
                end
            end
            FS_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FS_BOOT;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            instr_o     <= '0;
            pc_o        <= '0;
            valid_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            instr_o     <= instr_d;
            pc_o        <= pc_out_d;
            valid_o     <= valid_d;
        end
    end

endmodule
